// File: rtl/multi_counter.sv
// Multi-channel event/timer counter with a shared prescaler.
// Each channel counts up or down and flags compare match, wrap and one-shot done.
module multi_counter #(
  parameter int unsigned      NUM_CH      = 4,
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      PRESC_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [PRESC_W-1:0]      prescale_i,
  input  logic [NUM_CH*WIDTH-1:0] init_value_i,
  input  logic [NUM_CH*WIDTH-1:0] compare_value_i,
  input  logic [NUM_CH-1:0]       enable_i,
  input  logic [NUM_CH-1:0]       clear_i,
  input  logic [NUM_CH-1:0]       down_i,
  input  logic [NUM_CH-1:0]       oneshot_i,
  output logic [NUM_CH*WIDTH-1:0] counter_value_o,
  output logic [NUM_CH-1:0]       match_o,
  output logic [NUM_CH-1:0]       overflow_o,
  output logic [NUM_CH-1:0]       done_o
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [PRESC_W-1:0]           r_presc;
  logic [PRESC_W-1:0]           w_presc_nxt;
  logic                         w_tick;

  logic [NUM_CH-1:0][WIDTH-1:0] r_cnt;
  logic [NUM_CH-1:0][WIDTH-1:0] w_cnt_nxt;
  logic [NUM_CH-1:0][WIDTH-1:0] w_init;
  logic [NUM_CH-1:0][WIDTH-1:0] w_cmp;

  state_t                       r_state     [NUM_CH];
  state_t                       w_state_nxt [NUM_CH];

  logic [NUM_CH-1:0]            r_match;
  logic [NUM_CH-1:0]            r_ovf;
  logic [NUM_CH-1:0]            w_match_nxt;
  logic [NUM_CH-1:0]            w_ovf_nxt;

  assign w_init = init_value_i;
  assign w_cmp  = compare_value_i;

  // Shared prescaler: tick on terminal count, wraps naturally if overshot.
  always_comb begin
    w_tick      = (r_presc == prescale_i);
    w_presc_nxt = w_tick ? '0 : r_presc + PRESC_W'(1);
  end

  // Per-channel next state: clear, then done-hold, then match, then count.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_cnt_nxt[c]   = r_cnt[c];
      w_state_nxt[c] = r_state[c];
      w_match_nxt[c] = 1'b0;
      w_ovf_nxt[c]   = 1'b0;
      if (clear_i[c]) begin
        w_cnt_nxt[c]   = w_init[c];
        w_state_nxt[c] = ST_RUN;
      end else if (r_state[c] == ST_DONE) begin
        w_state_nxt[c] = ST_DONE;
      end else if (enable_i[c] && w_tick) begin
        if (r_cnt[c] == w_cmp[c]) begin
          w_match_nxt[c] = 1'b1;
          if (oneshot_i[c]) begin
            w_state_nxt[c] = ST_DONE;
          end else begin
            w_cnt_nxt[c] = w_init[c];
          end
        end else if (down_i[c]) begin
          w_cnt_nxt[c] = r_cnt[c] - WIDTH'(1);
          w_ovf_nxt[c] = (r_cnt[c] == '0);
        end else begin
          w_cnt_nxt[c] = r_cnt[c] + WIDTH'(1);
          w_ovf_nxt[c] = (r_cnt[c] == ALL_ONES);
        end
      end
    end
  end

  // State, count and pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_presc <= '0;
      r_cnt   <= {NUM_CH{RESET_VALUE}};
      r_match <= '0;
      r_ovf   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c] <= ST_RUN;
      end
    end else begin
      r_presc <= w_presc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_match <= w_match_nxt;
      r_ovf   <= w_ovf_nxt;
      for (int c = 0; c < NUM_CH; c++) begin
        r_state[c] <= w_state_nxt[c];
      end
    end
  end

  // Sticky done flag is simply the DONE state.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      done_o[c] = (r_state[c] == ST_DONE);
    end
  end

  assign counter_value_o = r_cnt;
  assign match_o         = r_match;
  assign overflow_o      = r_ovf;

endmodule

// File: doc/multi_counter.md
Name: multi_counter

Overview:
- Parametrised multi-channel event/timer counter; the successor of the single 32-bit up-counter.
- Adds the following per channel: configurable width, up/down direction, compare match, auto-reload or one-shot mode, and overflow flag.
- Adds one prescaler shared by all channels.
- Sits in SoC peripheral/timer subsystems and performance-counter banks. Software-facing register logic drives the configuration inputs and samples the outputs.

Parameters:
- NUM_CH, 4, number of independent counter channels (>=1)
- WIDTH, 32, counter width in bits (2..64)
- PRESC_W, 8, prescaler width in bits (>=1)
- RESET_VALUE, 0, counter value loaded on reset (WIDTH bits)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- prescale_i  in  PRESC_W  tick divider; tick every prescale_i+1 cycles
- init_value_i  in  NUM_CH*WIDTH  per-channel load/reload value, channel c at bits [c*WIDTH +: WIDTH]
- compare_value_i  in  NUM_CH*WIDTH  per-channel match value, same packing
- enable_i  in  NUM_CH  per-channel count enable
- clear_i  in  NUM_CH  per-channel synchronous load of init_value and restart
- down_i  in  NUM_CH  1 = count down, 0 = count up
- oneshot_i  in  NUM_CH  1 = stop on match, 0 = reload on match
- counter_value_o  out  NUM_CH*WIDTH  registered counter values, same packing
- match_o  out  NUM_CH  one-cycle pulse per match event
- overflow_o  out  NUM_CH  one-cycle pulse on wrap-around
- done_o  out  NUM_CH  sticky: one-shot channel stopped after match

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values:
  - counters = RESET_VALUE; prescaler count = 0
  - match_o, overflow_o, done_o = 0; all channels in RUN state
- Prescaler:
  - Free-running shared counter, counts every cycle regardless of enables.
  - tick = (presc_cnt == prescale_i); on tick, presc_cnt returns to 0, otherwise it increments.
  - prescale_i = 0 gives a tick every cycle.
  - If prescale_i changes to a value below presc_cnt, the prescaler wraps naturally at 2^PRESC_W, then ticks at the new value.
- Per-channel states: RUN, DONE.
- Per-channel priority, evaluated each cycle:
  1. clear_i = 1: count <= init_value; state <= RUN; done_o <= 0; no match or overflow pulse. Takes effect regardless of tick or enable.
  2. State DONE: count holds; done_o stays 1.
  3. enable_i & tick & (count_q == compare_value): match event.
     - match_o = 1 next cycle.
     - oneshot_i = 1: count holds; state <= DONE; done_o <= 1.
     - oneshot_i = 0: count <= init_value.
  4. enable_i & tick, no match: count <= count_q + 1 (up) or count_q - 1 (down), modulo 2^WIDTH.
     - Wrap up (all-ones -> 0) or down (0 -> all-ones) pulses overflow_o next cycle.
  5. Otherwise the count holds.
- Latency:
  - counter_value_o is the registered count; it reflects an update one cycle after the qualifying edge.
  - match_o and overflow_o are registered one-cycle pulses aligned with the updated counter_value_o.
- Match and overflow are mutually exclusive in one cycle: a match pre-empts the increment.
- Width rules: all arithmetic is WIDTH bits unsigned. Compare is exact equality.
- Match on the starting value: init_value == compare_value matches at the first qualifying tick after a clear.
- down_i and oneshot_i are sampled every cycle; changing them mid-count takes effect at the next qualifying tick.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Outputs are valid from the first clock after rst_i is deasserted.
- Channels are fully independent except for the shared tick.
- No combinational path from inputs to outputs.

Test Plan:
- Reset and basic up-count: WIDTH=32, prescale=0; assert rst_i, release; enable ch0 for 5 cycles -> counter_value_o[ch0] = 0,1,2,3,4,5; other channels stay 0.
- Prescaler: prescale=3, enable ch1 -> ch1 increments once every 4 cycles; after 16 cycles = 4. prescale=0 -> increments every cycle.
- Reload match: ch2 up, init=10, compare=13, oneshot=0, clear then enable -> sequence 10,11,12,13,10,11...; match_o pulses once per 4 ticks, aligned with the value returning to 10.
- One-shot and clear: ch3 down, init=3, compare=0, oneshot=1 -> 3,2,1,0, then holds 0; match_o one pulse; done_o = 1 stays. Clear -> value 3, done_o = 0, counting resumes.
- Wrap/overflow: WIDTH=8, up, init=0xFE, compare=0x10 -> 0xFE,0xFF,0x00 with overflow_o pulse at 0x00. Down from 0x00 -> 0xFF with overflow_o pulse.
- Priority and reset mid-operation: clear_i and a match on the same cycle -> init loaded, no match_o. Assert rst_i asynchronously mid-count -> all outputs = reset values before the next edge.
